// File: rtl/imem_pkg.sv
// Shared constants and FSM encoding for the instruction-memory boot loader.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W    = 8;
  localparam int unsigned IMEM_DATA_W    = 16;
  localparam logic [7:0]  IMEM_LAST_ADDR = 8'd254;
  localparam logic [7:0]  IMEM_PAD_BYTE  = 8'h00;

  typedef enum logic [2:0] {
    S_HI    = 3'd0,
    S_LO    = 3'd1,
    S_WRITE = 3'd2,
    S_FULL  = 3'd3,
    S_RUN   = 3'd4
  } imem_state_e;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot/reload controller: packs an rx byte stream into 16-bit words, writes them from
// address 0 while stalling the CPU, then hands the memory address port to instruction fetch.
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int unsigned      ADDR_W    = IMEM_ADDR_W,
  parameter int unsigned      DATA_W    = IMEM_DATA_W,
  parameter logic [7:0]       LAST_ADDR = IMEM_LAST_ADDR,
  parameter logic [7:0]       PAD_BYTE  = IMEM_PAD_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              load_end,
  input  logic              reload,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [ADDR_W:0]   words_loaded,
  output logic              load_overflow
);

  imem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]        hi_byte_q, hi_byte_d;
  logic              end_pend_q, end_pend_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_HI;
      wr_ptr_q    <= '0;
      hi_byte_q   <= '0;
      end_pend_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      words_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      hi_byte_q   <= hi_byte_d;
      end_pend_q  <= end_pend_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      words_q     <= words_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    hi_byte_d   = hi_byte_q;
    end_pend_d  = end_pend_q;
    mem_wdata_d = mem_wdata_q;
    words_d     = words_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      S_HI: begin
        if (rx_valid) begin
          if (load_end) begin
            // Image ends on a half word: pad the low byte and finish after this write.
            mem_wdata_d = {rx_data, PAD_BYTE};
            end_pend_d  = 1'b1;
            state_d     = S_WRITE;
          end else begin
            hi_byte_d = rx_data;
            state_d   = S_LO;
          end
        end else if (load_end) begin
          state_d = S_RUN;
        end
      end
      S_LO: begin
        if (rx_valid) begin
          mem_wdata_d = {hi_byte_q, rx_data};
          end_pend_d  = load_end;
          state_d     = S_WRITE;
        end else if (load_end) begin
          mem_wdata_d = {hi_byte_q, PAD_BYTE};
          end_pend_d  = 1'b1;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        words_d = words_q + 1'b1;
        if (end_pend_q) begin
          end_pend_d = 1'b0;
          state_d    = S_RUN;
        end else if (wr_ptr_q == LAST_ADDR) begin
          state_d = S_FULL;
        end else begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          state_d  = S_HI;
        end
      end
      S_FULL: begin
        // Keep draining the sender; every byte here is lost.
        if (rx_valid) ovf_d = 1'b1;
        if (load_end) state_d = S_RUN;
      end
      S_RUN: begin
        if (reload) begin
          state_d    = S_HI;
          wr_ptr_d   = '0;
          hi_byte_d  = '0;
          end_pend_d = 1'b0;
          words_d    = '0;
          ovf_d      = 1'b0;
        end
      end
      default: state_d = S_HI;
    endcase

    mem_we_d = (state_d == S_WRITE);
  end

  assign rx_ready      = rst_n && (state_q == S_HI || state_q == S_LO || state_q == S_FULL);
  assign cpu_hold      = (state_q != S_RUN);
  assign mem_add       = (state_q == S_RUN) ? fetch_addr : wr_ptr_q;
  assign mem_we        = mem_we_q;
  assign mem_wdata     = mem_wdata_q;
  assign words_loaded  = words_q;
  assign load_overflow = ovf_q;

  a_wr_ptr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    wr_ptr_q <= LAST_ADDR);
  a_write_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    mem_we |-> (mem_add <= LAST_ADDR));

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised scoreboard bench for imem_boot_loader with a behavioural instruction memory.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        load_end;
  logic        reload;
  logic [7:0]  fetch_addr;
  logic        cpu_hold;
  logic [7:0]  mem_add;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [8:0]  words_loaded;
  logic        load_overflow;
  logic [15:0] instruction_out;

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .load_end     (load_end),
    .reload       (reload),
    .fetch_addr   (fetch_addr),
    .cpu_hold     (cpu_hold),
    .mem_add      (mem_add),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .words_loaded (words_loaded),
    .load_overflow(load_overflow)
  );

  // Instruction memory: 255 words, synchronous write and registered read.
  logic [15:0] imem [0:254];
  always @(posedge clk) begin
    if (mem_we && mem_add <= 8'd254) imem[mem_add] <= mem_wdata;
    instruction_out <= (mem_add <= 8'd254) ? imem[mem_add] : 16'hDEAD;
  end

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    bit          last;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] mem_m [0:254];
  logic [7:0]  img_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          hold_pend = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the next expected write, in order.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (hold_pend) begin
        check("hold_fall_after_last_write", cpu_hold, 0);
        hold_pend = 0;
      end
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", mem_we, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_add, e.addr);
          check("wr_data", mem_wdata, e.data);
          check("hold_during_write", cpu_hold, 1);
          if (e.last) hold_pend = 1;
        end
      end
      if (rst_n && cpu_hold === 1'b1 && words_loaded === 9'd255 && mem_we === 1'b0)
        check("rx_ready_in_full", rx_ready, 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [7:0] b, input logic v, input logic last);
    int n = 0;
    rx_data  = b;
    rx_valid = v;
    load_end = last;
    reload   = ($urandom_range(0, 3) == 0);
    while (!rx_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_ready_timeout", rx_ready, 1);
    @(negedge clk);
    rx_valid = 0;
    load_end = 0;
    reload   = 0;
  endtask

  task automatic readback(input logic [7:0] a);
    fetch_addr = a;
    @(negedge clk);
    check("run_mem_add", mem_add, a);
    check("fetch_data", instruction_out, mem_m[a]);
  endtask

  task automatic do_reload();
    reload = 1;
    @(negedge clk);
    reload = 0;
    check("reload_hold", cpu_hold, 1);
    check("reload_words", words_loaded, 0);
    check("reload_ovf", load_overflow, 0);
    check("reload_add", mem_add, 0);
  endtask

  // Model: bytes pair high-first into words from address 0, odd tail padded with 00,
  // at most 255 words; anything beyond 510 bytes is dropped and flags overflow.
  task automatic load_image(input bit end_alone, input int gap_max);
    int  n = img_q.size();
    int  nw = ((n + 1) / 2 > 255) ? 255 : (n + 1) / 2;
    bit  ovf = (n > 510);
    bit  last_ok = !ovf && (!end_alone || (n % 2 == 1));
    int  t = 0;
    wr_t e;
    for (int k = 0; k < nw; k++) begin
      e.addr = 8'(k);
      e.data = {img_q[2*k], (2*k + 1 < n) ? img_q[2*k+1] : 8'h00};
      e.last = last_ok && (k == nw - 1);
      mem_m[k] = e.data;
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send(img_q[i], 1'b1, !end_alone && (i == n - 1));
    end
    if (end_alone) begin
      repeat (gap_max) @(negedge clk);
      send(8'h00, 1'b0, 1'b1);
    end
    while (cpu_hold && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("run_reached", cpu_hold, 0);
    @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("words_loaded", words_loaded, nw);
    check("load_overflow", load_overflow, ovf);
    for (int k = 0; k < nw; k++) readback(8'(k));
  endtask

  task automatic check_reset_state();
    check("rst_rx_ready", rx_ready, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_words", words_loaded, 0);
    check("rst_ovf", load_overflow, 0);
    check("rst_mem_add", mem_add, 0);
  endtask

  initial begin
    for (int k = 0; k < 255; k++) begin
      imem[k]  = 16'h0000;
      mem_m[k] = 16'h0000;
    end
    rst_n = 0; rx_data = 0; rx_valid = 0; load_end = 0; reload = 0; fetch_addr = 0;
    @(negedge clk);
    check("rst_rx_ready_first", rx_ready, 0);
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1;
    @(negedge clk);
    check("post_rst_rx_ready", rx_ready, 1);

    // Four bytes, end marked on the last byte.
    img_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    load_image(1'b0, 0);
    readback(8'd1);

    // Reload overwrites word 0 only; word 1 keeps the previous image.
    do_reload();
    img_q = '{8'h99, 8'h88};
    load_image(1'b0, 2);
    readback(8'd1);

    // Odd image, end on the last byte.
    do_reload();
    img_q = '{8'hAB, 8'hCD, 8'hEF};
    load_image(1'b0, 1);

    // Single byte, end arrives alone three cycles later.
    do_reload();
    img_q = '{8'hAB};
    load_image(1'b1, 3);

    // 512 bytes overflow the memory.
    do_reload();
    img_q.delete();
    for (int i = 0; i < 512; i++) img_q.push_back(8'($urandom));
    load_image(1'b0, 0);

    // Reset in the middle of a word discards the captured high byte.
    do_reload();
    send(8'h12, 1'b1, 1'b0);
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    check_reset_state();
    rst_n = 1;
    @(negedge clk);
    img_q = '{8'h34, 8'h56};
    load_image(1'b0, 1);
    readback(8'd1);

    // Random images, random gaps, random end style.
    for (int r = 0; r < 8; r++) begin
      int  n = $urandom_range(0, 24);
      bit  ea = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      do_reload();
      img_q.delete();
      for (int i = 0; i < n; i++) img_q.push_back(8'($urandom));
      load_image(ea, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
